seg_mux_capture: RTL and testbench
==================================

Name: seg_mux_capture

Overview:
- Inverse of the team's hex-to-7-segment decoder; recovers hex digits from a time-multiplexed two-digit display bus.
- Samples the active-low segment lines and active-low anode enables, and requires a pattern to be stable for a minimum number of cycles before accepting it.
- Maps each accepted pattern back to its 4-bit code and holds one digit register per display position.
- Used as an on-chip self-check of the display path and as a bench monitor.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples (seg and an) required before acceptance; legal range 2..255.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- seg  input  7  segment lines seg[6:0], active low, same bit order as the display decoder output
- an  input  2  anode enables, active low; an[0] = digit0 (right), an[1] = digit1 (left)
- err_clr  input  1  clears err on the next edge
- digit0  output  4  last accepted code for digit0
- digit1  output  4  last accepted code for digit1
- valid  output  2  valid[n] = 1 when digitn holds a code from a legal non-blank pattern
- update  output  1  one-cycle pulse on any digit/valid write
- err  output  1  sticky flag for illegal pattern or anode conflict

Behaviour:
- Reset (synchronous, edge with reset=1):
  - digit0 = digit1 = 0, valid = 00, update = 0, err = 0.
  - Stability counter cnt = 0; prev_seg = 1111111; prev_an = 11.
  - Reset wins over every other event.
- Stability counter:
  - At each edge: if {seg,an} == {prev_seg,prev_an} and cnt != 0, then cnt <= min(cnt+1, STABLE_CYCLES); otherwise cnt <= 1.
  - prev registers load the current sample every edge.
- Acceptance:
  - Occurs on the edge where cnt == STABLE_CYCLES-1 and the sample equals prev. This is the STABLE_CYCLES-th identical sample.
  - Fires once per stable run; the saturated counter blocks re-acceptance.
  - Outputs update on that same edge: inputs stable before edge 0 give updated outputs after edge STABLE_CYCLES-1.
- Target select at acceptance:
  - an=10 → digit0; an=01 → digit1.
  - an=11 → no target: no write, no err, no update.
  - an=00 → conflict: err <= 1, no write, no update.
- Pattern decode (seg[6:0] → code):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0011000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
- Outcome at acceptance with a valid target:
  - Legal code: digitN <= code, valid[N] <= 1, update = 1.
  - Blank 1111111: valid[N] <= 0, digitN unchanged, update = 1.
  - Any other pattern: err <= 1, no write, update = 0.
- Glitch filtering: a run shorter than STABLE_CYCLES produces no write and no err, so multiplex-switch glitches are ignored.
- err behaviour:
  - Sticky until reset or err_clr.
  - err_clr and a new error event in the same cycle: err remains 1 (set wins).
- update: high exactly one cycle per write; otherwise 0.
- Digit independence: a write to one digit never alters the other digit's code or valid bit.
- Reset mid-run: the partial count is discarded; a full STABLE_CYCLES run is needed after reset deasserts.

Test Plan:
1. Reset, then an=10, seg=0100100 held 4 edges → digit0=2, valid=01, update=1 only on the 4th edge; digit1=0.
2. an=01, seg=0001110 for 3 edges, then seg=1111000 for 4 edges → no update after the first run; after the second, digit1=7, valid=10.
3. Sweep all 16 legal patterns on an=10, 4 edges each → digit0 steps 0..F in order; 16 update pulses; err=0 throughout.
4. seg=1010101 stable 4 edges on an=10 → err=1, digit0 unchanged, no update. Then err_clr=1 → err=0. Then err_clr=1 on the same edge as a new illegal acceptance → err=1.
5. digit1=7 valid, then seg=1111111 on an=01 for 4 edges → valid[1]=0, digit1 stays 7, update pulses once. Then an=00 stable 4 edges → err=1, no digit change.
6. Assert reset on the 3rd edge of a 4-edge run on an=10 → all outputs 0. Sample held afterwards → acceptance only on the 4th edge after reset deasserts.

Source files
------------

// File: rtl/seg_mux_capture_if.sv
// Bus between a two-digit multiplexed 7-segment display and its capture monitor.
// The display side drives segments/anodes and the capture side reports the decoded digits.
interface seg_mux_capture_if;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err_clr;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [1:0] valid;
    logic       update;
    logic       err;

    modport master (
        output seg, an, err_clr,
        input  digit0, digit1, valid, update, err
    );

    modport slave (
        input  seg, an, err_clr,
        output digit0, digit1, valid, update, err
    );
endinterface

// File: rtl/seg_mux_capture.sv
// Recovers hex digits from a time-multiplexed, active-low two-digit 7-segment bus.
// A {seg,an} sample must repeat STABLE_CYCLES times before it is decoded and written.
module seg_mux_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    seg_mux_capture_if.slave   bus
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

    logic [6:0] prev_seg_q;
    logic [1:0] prev_an_q;
    logic [7:0] cnt_q, cnt_d;
    logic       update_q, update_d;
    logic       err_q, err_d;

    logic       same_sample;
    logic       accept;
    logic       legal;
    logic       blank;
    logic [3:0] code;
    logic [1:0] tgt_sel;
    logic       conflict;
    logic       err_set;
    logic [1:0] wr_code;
    logic [1:0] wr_blank;
    logic [1:0] valid_w;
    logic [1:0][3:0] digit_w;

    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0_0000;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0011000: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        same_sample = ({bus.seg, bus.an} == {prev_seg_q, prev_an_q});
        cnt_d       = 8'd1;
        if (same_sample && (cnt_q != 8'd0)) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end
        // The saturated count never equals CNT_ACC again, so a run is accepted once.
        accept = same_sample && (cnt_q == CNT_ACC);

        {legal, code} = decode_seg(bus.seg);
        blank         = (bus.seg == 7'b1111111);
        tgt_sel[0]    = (bus.an == 2'b10);
        tgt_sel[1]    = (bus.an == 2'b01);
        conflict      = (bus.an == 2'b00);

        wr_code  = {2{accept & legal}} & tgt_sel;
        wr_blank = {2{accept & blank}} & tgt_sel;
        update_d = |(wr_code | wr_blank);

        err_set = accept & (conflict | ((|tgt_sel) & ~legal & ~blank));
        err_d   = err_set | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_seg_q <= 7'b1111111;
            prev_an_q  <= 2'b11;
            cnt_q      <= 8'd0;
            update_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            prev_seg_q <= bus.seg;
            prev_an_q  <= bus.an;
            cnt_q      <= cnt_d;
            update_q   <= update_d;
            err_q      <= err_d;
        end
    end

    // One code/valid register pair per display position; writes never cross positions.
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
        logic [3:0] digit_q;
        logic       valid_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                digit_q <= 4'h0;
                valid_q <= 1'b0;
            end else if (wr_code[gi]) begin
                digit_q <= code;
                valid_q <= 1'b1;
            end else if (wr_blank[gi]) begin
                valid_q <= 1'b0;
            end
        end

        assign digit_w[gi] = digit_q;
        assign valid_w[gi] = valid_q;
    end

    assign bus.digit0 = digit_w[0];
    assign bus.digit1 = digit_w[1];
    assign bus.valid  = valid_w;
    assign bus.update = update_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_seg_mux_capture.sv
// Self-checking bench for seg_mux_capture: directed vector table, digit sweep,
// and random runs compared every cycle against a history-based reference model.
module tb_seg_mux_capture;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg_mux_capture_if bus ();

    seg_mux_capture #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [6:0] seg;
        logic [1:0] an;
        logic       clr;
        logic       rst;
        int         n;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [1:0] v;
        logic       upd;
        logic       err;
    } vec_t;

    vec_t tbl [$];

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: full-sample history since reset (trimmed to S+1).
    logic [8:0] hist [$];
    logic [3:0] m_d [2];
    logic [1:0] m_v;
    logic       m_upd;
    logic       m_err;

    function automatic vec_t mk(input logic [6:0] seg, input logic [1:0] an, input logic clr,
                                input logic rst, input int n, input logic [3:0] d0,
                                input logic [3:0] d1, input logic [1:0] v,
                                input logic upd, input logic err);
        vec_t r;
        r.seg = seg; r.an = an; r.clr = clr; r.rst = rst; r.n = n;
        r.d0 = d0; r.d1 = d1; r.v = v; r.upd = upd; r.err = err;
        return r;
    endfunction

    task automatic model_step();
        logic [8:0] s;
        bit         acc;
        bit         eset;
        bit         found;
        int         idx;
        int         code;
        if (reset) begin
            m_d[0] = 4'h0; m_d[1] = 4'h0; m_v = 2'b00; m_upd = 1'b0; m_err = 1'b0;
            hist.delete();
        end else begin
            s = {bus.seg, bus.an};
            hist.push_back(s);
            if (hist.size() > S + 1) void'(hist.pop_front());
            m_upd = 1'b0;
            eset  = 1'b0;
            // Accept when the last S samples match and the run is exactly S long.
            acc = (hist.size() >= S);
            if (acc) begin
                for (int k = 1; k < S; k++)
                    if (hist[hist.size() - 1 - k] != s) acc = 0;
                if (hist.size() == S + 1 && hist[0] == s) acc = 0;
            end
            if (acc) begin
                if (bus.an == 2'b00) begin
                    eset = 1;
                end else if (bus.an != 2'b11) begin
                    idx = (bus.an == 2'b10) ? 0 : 1;
                    found = 0;
                    code = 0;
                    for (int c = 0; c < 16; c++)
                        if (pat[c] == bus.seg) begin found = 1; code = c; end
                    if (found) begin
                        m_d[idx] = 4'(code);
                        m_v[idx] = 1'b1;
                        m_upd = 1'b1;
                    end else if (bus.seg == 7'h7F) begin
                        m_v[idx] = 1'b0;
                        m_upd = 1'b1;
                    end else begin
                        eset = 1;
                    end
                end
            end
            m_err = eset ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
        end
    endtask

    task automatic tick();
        logic [11:0] act;
        logic [11:0] exp;
        @(posedge clk);
        #1;
        model_step();
        act = {bus.digit1, bus.digit0, bus.valid, bus.update, bus.err};
        exp = {m_d[1], m_d[0], m_v, m_upd, m_err};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL model t=%0t {d1,d0,v,upd,err} got %h want %h", $time, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] seg, input logic [1:0] an, input logic clr,
                         input logic rst, input int n);
        bus.seg = seg; bus.an = an; bus.err_clr = clr; reset = rst;
        repeat (n) tick();
    endtask

    initial begin
        logic [11:0] act;
        logic [11:0] exp;
        int          upd_cnt;
        int          kind;
        logic [6:0]  rs;
        logic [1:0]  ra;

        bus.seg = 7'h7F; bus.an = 2'b11; bus.err_clr = 1'b0;

        //            seg     an    clr  rst  n  d0    d1    v      upd  err
        tbl.push_back(mk(7'h7F, 2'b11, 0, 1, 2, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 3, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 1, 4'h2, 4'h0, 2'b01, 1, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 1, 4'h2, 4'h0, 2'b01, 0, 0));
        tbl.push_back(mk(7'h0E, 2'b01, 0, 0, 3, 4'h2, 4'h0, 2'b01, 0, 0));
        tbl.push_back(mk(7'h78, 2'b01, 0, 0, 4, 4'h2, 4'h7, 2'b11, 1, 0));
        tbl.push_back(mk(7'h55, 2'b10, 0, 0, 4, 4'h2, 4'h7, 2'b11, 0, 1));
        tbl.push_back(mk(7'h55, 2'b10, 1, 0, 1, 4'h2, 4'h7, 2'b11, 0, 0));
        tbl.push_back(mk(7'h56, 2'b10, 0, 0, 3, 4'h2, 4'h7, 2'b11, 0, 0));
        tbl.push_back(mk(7'h56, 2'b10, 1, 0, 1, 4'h2, 4'h7, 2'b11, 0, 1));
        tbl.push_back(mk(7'h56, 2'b10, 0, 0, 1, 4'h2, 4'h7, 2'b11, 0, 1));
        tbl.push_back(mk(7'h7F, 2'b11, 1, 0, 1, 4'h2, 4'h7, 2'b11, 0, 0));
        tbl.push_back(mk(7'h7F, 2'b01, 0, 0, 4, 4'h2, 4'h7, 2'b01, 1, 0));
        tbl.push_back(mk(7'h24, 2'b00, 0, 0, 4, 4'h2, 4'h7, 2'b01, 0, 1));
        tbl.push_back(mk(7'h24, 2'b10, 0, 1, 1, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 2, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 1, 1, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 3, 4'h0, 4'h0, 2'b00, 0, 0));
        tbl.push_back(mk(7'h24, 2'b10, 0, 0, 1, 4'h2, 4'h0, 2'b01, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].seg, tbl[i].an, tbl[i].clr, tbl[i].rst, tbl[i].n);
            act = {bus.digit1, bus.digit0, bus.valid, bus.update, bus.err};
            exp = {tbl[i].d1, tbl[i].d0, tbl[i].v, tbl[i].upd, tbl[i].err};
            n_vec++;
            if (act !== exp) begin
                n_mis++;
                $display("FAIL tbl[%0d] {d1,d0,v,upd,err} got %h want %h", i, act, exp);
            end
        end

        // Sweep every legal pattern onto digit0.
        drive(7'h7F, 2'b11, 0, 1, 1);
        upd_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            bus.seg = pat[c]; bus.an = 2'b10; bus.err_clr = 1'b0; reset = 1'b0;
            for (int e = 0; e < S; e++) begin
                tick();
                if (bus.update === 1'b1) upd_cnt++;
            end
            act = {4'h0, bus.digit0, bus.valid, bus.update, bus.err};
            exp = {4'h0, 4'(c), 2'b01, 1'b1, 1'b0};
            n_vec++;
            if (act !== exp) begin
                n_mis++;
                $display("FAIL sweep[%0d] {d0,v,upd,err} got %h want %h", c, act[7:0], exp[7:0]);
            end
        end
        n_vec++;
        if (upd_cnt != 16) begin
            n_mis++;
            $display("FAIL sweep_pulses got %0d want 16", upd_cnt);
        end

        // Random runs of mixed patterns, anodes, lengths, clears and resets.
        for (int r = 0; r < 400; r++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 6)       rs = pat[$urandom_range(0, 15)];
            else if (kind < 8)  rs = 7'h7F;
            else                rs = 7'($urandom);
            ra = 2'($urandom);
            drive(rs, ra, ($urandom % 8) == 0, ($urandom % 40) == 0,
                  int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
